// File: rtl/alu_pkg.sv
// Shared ALU constants: default datapath width and the flag compare patterns.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    localparam logic [ALU_WIDTH-1:0] ALU_ZERO = '0;
    localparam logic [ALU_WIDTH-1:0] ALU_ONES = '1;

endpackage

// File: rtl/or_32_if.sv
// Operand/result bundle for the OR unit; master drives operands, slave returns results.
interface or_32_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] Ra;
    logic [WIDTH-1:0] Rb;
    logic             en;
    logic [WIDTH-1:0] Rz;
    logic [WIDTH-1:0] Rz_q;
    logic             valid_q;
    logic             zero_q;
    logic             ones_q;

    modport master (
        output Ra, Rb, en,
        input  Rz, Rz_q, valid_q, zero_q, ones_q
    );

    modport slave (
        input  Ra, Rb, en,
        output Rz, Rz_q, valid_q, zero_q, ones_q
    );
endinterface

// File: rtl/or_bitwise.sv
// Combinational WIDTH-bit OR core, one gate per bit so the ALU can reuse it directly.
module or_bitwise
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign y[i] = a[i] | b[i];
    end

endmodule

// File: rtl/or_32.sv
// ALU OR unit: zero-latency Rz for the result mux plus a captured copy with zero/ones flags.
module or_32
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic    clock,
    input  logic    reset,
    or_32_if.slave  bus
);

    logic [WIDTH-1:0] rz;
    logic             is_zero;
    logic             is_ones;

    or_bitwise #(
        .WIDTH (WIDTH)
    ) u_or (
        .a (bus.Ra),
        .b (bus.Rb),
        .y (rz)
    );

    assign bus.Rz = rz;

    // Package patterns cover the native width; other widths fall back to reductions.
    if (WIDTH == ALU_WIDTH) begin : g_flag_const
        assign is_zero = (rz == ALU_ZERO);
        assign is_ones = (rz == ALU_ONES);
    end else begin : g_flag_reduce
        assign is_zero = ~|rz;
        assign is_ones = &rz;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.Rz_q    <= '0;
            bus.valid_q <= 1'b0;
            bus.zero_q  <= 1'b0;
            bus.ones_q  <= 1'b0;
        end else if (bus.en) begin
            bus.Rz_q    <= rz;
            bus.valid_q <= 1'b1;
            bus.zero_q  <= is_zero;
            bus.ones_q  <= is_ones;
        end
    end

endmodule

// File: tb/tb_or_32.sv
// Self-checking bench for or_32: vector table, no-clock settle check and random regression.
module tb_or_32;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] ra;
        logic [31:0] rb;
        logic        en;
        logic        rst;
        logic [31:0] exp_rz;
        logic        exp_zero;
        logic        exp_ones;
    } vec_t;

    typedef struct {
        logic [31:0] rzq;
        logic        valid;
        logic        zero;
        logic        ones;
    } reg_exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic clk_run = 1'b1;

    int unsigned checks = 0;
    int unsigned passed = 0;

    reg_exp_t sb_q[$];
    reg_exp_t model;

    or_32_if #(.WIDTH(32)) bus ();

    or_32 #(
        .WIDTH (32)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always begin
        #5;
        if (clk_run) clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle, check Rz before the edge and the registered path after it.
    task automatic step(input logic [31:0] ra, input logic [31:0] rb, input logic en,
                        input logic rst, input logic [31:0] exp_rz,
                        input logic exp_zero, input logic exp_ones);
        reg_exp_t got;
        bus.Ra = ra;
        bus.Rb = rb;
        bus.en = en;
        reset  = rst;
        #1;
        check("Rz", bus.Rz, exp_rz);
        if (rst) model = '{32'h0, 1'b0, 1'b0, 1'b0};
        else if (en) model = '{exp_rz, 1'b1, exp_zero, exp_ones};
        sb_q.push_back(model);
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            check("Rz_q", bus.Rz_q, got.rzq);
            check("valid_q", {31'd0, bus.valid_q}, {31'd0, got.valid});
            check("zero_q", {31'd0, bus.zero_q}, {31'd0, got.zero});
            check("ones_q", {31'd0, bus.ones_q}, {31'd0, got.ones});
        end
    endtask

    vec_t vecs[10];

    initial begin
        logic [31:0] ra, rb, exp_rz;
        logic        en, rst;

        model   = '{32'h0, 1'b0, 1'b0, 1'b0};
        bus.Ra  = '0;
        bus.Rb  = '0;
        bus.en  = 1'b0;

        vecs[0] = '{32'hDEADBEEF, 32'h00000000, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[1] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1};
        vecs[4] = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1};
        vecs[5] = '{32'h12345678, 32'h87654321, 1'b1, 1'b0, 32'h97755779, 1'b0, 1'b0};
        vecs[6] = '{32'h0F0F0000, 32'h000000F0, 1'b0, 1'b0, 32'h0F0F00F0, 1'b0, 1'b0};
        vecs[7] = '{32'h00000001, 32'h00000000, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0};
        vecs[8] = '{32'h12345678, 32'h87654321, 1'b1, 1'b1, 32'h97755779, 1'b0, 1'b0};
        vecs[9] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};

        for (int i = 0; i < 10; i++)
            step(vecs[i].ra, vecs[i].rb, vecs[i].en, vecs[i].rst,
                 vecs[i].exp_rz, vecs[i].exp_zero, vecs[i].exp_ones);

        // Capture a result, then stop the clock: Rz must settle on its own, Rz_q must hold.
        step(32'h12345678, 32'h87654321, 1'b1, 1'b0, 32'h97755779, 1'b0, 1'b0);
        clk_run = 1'b0;
        bus.en  = 1'b1;
        bus.Ra  = 32'h00F00000;
        bus.Rb  = 32'h0000000F;
        #10;
        check("Rz_noclock", bus.Rz, 32'h00F0000F);
        check("Rz_q_noclock", bus.Rz_q, 32'h97755779);
        bus.Ra  = 32'h80000000;
        bus.Rb  = 32'h00000001;
        #10;
        check("Rz_noclock2", bus.Rz, 32'h80000001);
        clk_run = 1'b1;

        // Back-to-back captures then a mid-stream reset.
        step(32'h00000010, 32'h00000100, 1'b1, 1'b0, 32'h00000110, 1'b0, 1'b0);
        step(32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1);
        step(32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);
        step(32'hCAFEF00D, 32'h01010101, 1'b0, 1'b1, 32'hCBFFF10D, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 9))
                0: begin ra = 32'h0; rb = 32'h0; end
                1: begin ra = $urandom(); rb = ~ra; end
                default: begin ra = $urandom(); rb = $urandom(); end
            endcase
            en     = ($urandom_range(0, 1) == 1);
            rst    = ($urandom_range(0, 19) == 0);
            exp_rz = ra | rb;
            step(ra, rb, en, rst, exp_rz, exp_rz == ALU_ZERO, exp_rz == ALU_ONES);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
